// File: rtl/bias_add_unit.sv
// Bias bank plus two-stage bias-add pipeline for adder-tree result vectors.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   ld_valid/ld_grp/ld_data   bias vector write; never back-pressured
//   in_valid/in_ready/in_grp/in_data/relu_en   input vector handshake
//   out_valid/out_ready/out_data   biased, saturated result handshake
// Lane i of every vector occupies bits [W*(i+1)-1:W*i], two's complement.
module bias_add_unit #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned W            = 18,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned AW           = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_valid,
  input  logic [AW-1:0]             ld_grp,
  input  logic [N_adder_tree*W-1:0] ld_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [AW-1:0]             in_grp,
  input  logic [N_adder_tree*W-1:0] in_data,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_adder_tree*W-1:0] out_data
);

  localparam int unsigned VW = N_adder_tree * W;

  logic [VW-1:0] bank [DEPTH];
  logic          adv;
  logic          ld_hit;
  logic          in_hit;
  logic [VW-1:0] bias_rd_c;
  logic [VW-1:0] sum_c;

  logic          s1_valid;
  logic          s1_relu;
  logic [VW-1:0] s1_data;
  logic [VW-1:0] s1_bias;

  // Single advance for the whole pipeline; in_ready is combinational from it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Out-of-range group indices only exist for non-power-of-two DEPTH.
  assign ld_hit = ld_valid && (32'(ld_grp) < DEPTH);
  assign in_hit = 32'(in_grp) < DEPTH;

  // Bias bank; reset has priority over a same-cycle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        bank[i] <= '0;
      end
    end else if (ld_hit) begin
      bank[ld_grp] <= ld_data;
    end
  end

  // Read of the pre-edge bank, so a same-cycle load is seen only by later inputs.
  always_comb begin
    bias_rd_c = '0;
    if (in_hit) begin
      bias_rd_c = bank[in_grp];
    end
  end

  // Stage 1: snapshot of data, relu flag and bias for the accepted input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_relu  <= 1'b0;
      s1_data  <= '0;
      s1_bias  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_relu <= relu_en;
        s1_data <= in_data;
        s1_bias <= bias_rd_c;
      end
    end
  end

  // One lane: W+1-bit sum, saturate on sign disagreement, then optional ReLU.
  function automatic logic [W-1:0] lane_add(input logic [W-1:0] d,
                                            input logic [W-1:0] b,
                                            input logic         relu);
    logic [W:0]   s;
    logic [W-1:0] r;
    s = {d[W-1], d} + {b[W-1], b};
    if (s[W] != s[W-1]) begin
      r = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      r = s[W-1:0];
    end
    if (relu && r[W-1]) begin
      r = '0;
    end
    return r;
  endfunction

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N_adder_tree); i++) begin
      sum_c[i*W +: W] = lane_add(s1_data[i*W +: W], s1_bias[i*W +: W], s1_relu);
    end
  end

  // Stage 2: registered result; out_data holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sum_c;
      end
    end
  end

endmodule
